// File: rtl/fss_i2c_arb_pkg.sv
// Shared types for the I2C master arbiter: FSM state encoding and the latched
// register-transaction descriptor handed to the master engine.
package fss_i2c_arb_pkg;

    localparam int C_I2C_ADDR_W = 7;
    localparam int C_I2C_DATA_W = 8;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_ISSUE = 2'd1,
        ST_WAIT  = 2'd2,
        ST_RESP  = 2'd3
    } arb_state_e;

    // Field "reg_idx" carries the 8-bit target register index.
    typedef struct packed {
        logic [C_I2C_ADDR_W-1:0] addr;
        logic                    rw;
        logic [C_I2C_DATA_W-1:0] reg_idx;
        logic [C_I2C_DATA_W-1:0] wdata;
    } i2c_desc_t;

endpackage

// File: rtl/fss_rr_picker.sv
// Combinational N-way round-robin picker: first set request at or after the
// pointer, wrapping from N-1 back to 0.
module fss_rr_picker #(
    parameter int P_N  = 2,
    parameter int P_IW = (P_N > 1) ? $clog2(P_N) : 1
) (
    input  logic [P_N-1:0]  req_i,
    input  logic [P_IW-1:0] ptr_i,
    output logic [P_N-1:0]  gnt_oh_o,
    output logic [P_IW-1:0] gnt_idx_o,
    output logic            valid_o
);

    always_comb begin
        int j;
        j         = 0;
        gnt_oh_o  = '0;
        gnt_idx_o = '0;
        valid_o   = 1'b0;
        for (int k = 0; k < P_N; k++) begin
            j = (int'(ptr_i) + k) % P_N;
            if (!valid_o && req_i[j]) begin
                gnt_oh_o[j] = 1'b1;
                gnt_idx_o   = P_IW'(j);
                valid_o     = 1'b1;
            end
        end
    end

endmodule

// File: rtl/fss_i2c_arbiter.sv
// Round-robin arbiter sharing one I2C master between P_NUM_REQ clients, one
// register transaction per grant. Optional WAIT watchdog: FSS_I2C_ARB_TIMEOUT_EN.
module fss_i2c_arbiter
    import fss_i2c_arb_pkg::*;
#(
    parameter int P_NUM_REQ        = 2,
    parameter int P_TIMEOUT_CYCLES = 500000
) (
    input  logic                   I_CLK,
    input  logic                   I_NRESET,
    input  logic [P_NUM_REQ-1:0]   I_REQ,
    input  logic [7*P_NUM_REQ-1:0] I_REQ_ADDR,
    input  logic [P_NUM_REQ-1:0]   I_REQ_RW,
    input  logic [8*P_NUM_REQ-1:0] I_REQ_REG,
    input  logic [8*P_NUM_REQ-1:0] I_REQ_WDATA,
    output logic [P_NUM_REQ-1:0]   O_GNT,
    output logic [P_NUM_REQ-1:0]   O_DONE,
    output logic [7:0]             O_RDATA,
    output logic                   O_NACK,
    output logic                   O_TIMEOUT,
    output logic                   O_M_START,
    output logic [6:0]             O_M_ADDR,
    output logic                   O_M_RW,
    output logic [7:0]             O_M_REG,
    output logic [7:0]             O_M_WDATA,
    input  logic                   I_M_BUSY,
    input  logic                   I_M_DONE,
    input  logic                   I_M_NACK,
    input  logic [7:0]             I_M_RDATA,
    output arb_state_e             O_DBG_STATE
);

    localparam int C_IW = (P_NUM_REQ > 1) ? $clog2(P_NUM_REQ) : 1;

    arb_state_e           state_q;
    logic [C_IW-1:0]      ptr_q;
    logic [C_IW-1:0]      idx_q;
    logic [P_NUM_REQ-1:0] gnt_q;
    logic [P_NUM_REQ-1:0] done_q;
    logic [7:0]           rdata_q;
    logic                 nack_q;
    logic                 start_q;
    i2c_desc_t            desc_q;

    logic [P_NUM_REQ-1:0] pick_oh;
    logic [C_IW-1:0]      pick_idx;
    logic                 pick_valid;
    i2c_desc_t            pick_desc;

    fss_rr_picker #(
        .P_N  (P_NUM_REQ),
        .P_IW (C_IW)
    ) u_picker (
        .req_i     (I_REQ),
        .ptr_i     (ptr_q),
        .gnt_oh_o  (pick_oh),
        .gnt_idx_o (pick_idx),
        .valid_o   (pick_valid)
    );

    // Mux the winner's descriptor out of the flattened per-client buses.
    always_comb begin
        pick_desc = '0;
        for (int i = 0; i < P_NUM_REQ; i++) begin
            if (pick_oh[i]) begin
                pick_desc.addr    = I_REQ_ADDR[i*7 +: 7];
                pick_desc.rw      = I_REQ_RW[i];
                pick_desc.reg_idx = I_REQ_REG[i*8 +: 8];
                pick_desc.wdata   = I_REQ_WDATA[i*8 +: 8];
            end
        end
    end

`ifdef FSS_I2C_ARB_TIMEOUT_EN
    logic [31:0] cnt_q;
    logic        timeout_q;
    assign O_TIMEOUT = timeout_q;
`else
    assign O_TIMEOUT = 1'b0;
`endif

    always_ff @(posedge I_CLK or negedge I_NRESET) begin
        if (!I_NRESET) begin
            state_q   <= ST_IDLE;
            ptr_q     <= '0;
            idx_q     <= '0;
            gnt_q     <= '0;
            done_q    <= '0;
            rdata_q   <= 8'h00;
            nack_q    <= 1'b0;
            start_q   <= 1'b0;
            desc_q    <= '0;
`ifdef FSS_I2C_ARB_TIMEOUT_EN
            cnt_q     <= '0;
            timeout_q <= 1'b0;
`endif
        end else begin
            start_q   <= 1'b0;
            done_q    <= '0;
`ifdef FSS_I2C_ARB_TIMEOUT_EN
            timeout_q <= 1'b0;
`endif
            case (state_q)
                ST_IDLE: begin
                    if (pick_valid && !I_M_BUSY) begin
                        gnt_q   <= pick_oh;
                        idx_q   <= pick_idx;
                        desc_q  <= pick_desc;
                        state_q <= ST_ISSUE;
                    end
                end
                ST_ISSUE: begin
                    // Registered, so the pulse is seen in the first WAIT cycle.
                    start_q <= 1'b1;
                    state_q <= ST_WAIT;
`ifdef FSS_I2C_ARB_TIMEOUT_EN
                    cnt_q   <= '0;
`endif
                end
                ST_WAIT: begin
                    if (I_M_DONE) begin
                        rdata_q <= I_M_RDATA;
                        nack_q  <= I_M_NACK;
                        done_q  <= gnt_q;
                        state_q <= ST_RESP;
                    end
`ifdef FSS_I2C_ARB_TIMEOUT_EN
                    else if (cnt_q == 32'(P_TIMEOUT_CYCLES - 1)) begin
                        rdata_q   <= 8'hFF;
                        nack_q    <= 1'b1;
                        done_q    <= gnt_q;
                        timeout_q <= 1'b1;
                        state_q   <= ST_RESP;
                    end else begin
                        cnt_q <= cnt_q + 32'd1;
                    end
`endif
                end
                ST_RESP: begin
                    gnt_q   <= '0;
                    ptr_q   <= (idx_q == C_IW'(P_NUM_REQ - 1)) ? '0 : idx_q + 1'b1;
                    state_q <= ST_IDLE;
                end
                default: state_q <= ST_IDLE;
            endcase
        end
    end

    assign O_GNT       = gnt_q;
    assign O_DONE      = done_q;
    assign O_RDATA     = rdata_q;
    assign O_NACK      = nack_q;
    assign O_M_START   = start_q;
    assign O_M_ADDR    = desc_q.addr;
    assign O_M_RW      = desc_q.rw;
    assign O_M_REG     = desc_q.reg_idx;
    assign O_M_WDATA   = desc_q.wdata;
    assign O_DBG_STATE = state_q;

endmodule

// File: tb/tb_fss_i2c_arbiter.sv
// Directed bench for fss_i2c_arbiter: vector table plus hand sequences for
// latency, contention, reset-in-WAIT and (with FSS_I2C_ARB_TIMEOUT_EN) watchdog.
module tb_fss_i2c_arbiter;
    import fss_i2c_arb_pkg::*;

    localparam int N = 2;

    logic           clk = 1'b0;
    logic           rst_n;
    logic [N-1:0]   req;
    logic [7*N-1:0] req_addr;
    logic [N-1:0]   req_rw;
    logic [8*N-1:0] req_reg;
    logic [8*N-1:0] req_wdata;
    logic [N-1:0]   gnt, done;
    logic [7:0]     rdata;
    logic           nack, tmo, m_start;
    logic [6:0]     m_addr;
    logic           m_rw;
    logic [7:0]     m_reg, m_wdata;
    logic           m_busy, m_done, m_nack;
    logic [7:0]     m_rdata;
    arb_state_e     dbg_state;

    int pass_cnt  = 0;
    int total_cnt = 0;
    int multi_gnt = 0;

    always #5 clk = ~clk;

    fss_i2c_arbiter #(
        .P_NUM_REQ        (N),
        .P_TIMEOUT_CYCLES (100)
    ) dut (
        .I_CLK       (clk),
        .I_NRESET    (rst_n),
        .I_REQ       (req),
        .I_REQ_ADDR  (req_addr),
        .I_REQ_RW    (req_rw),
        .I_REQ_REG   (req_reg),
        .I_REQ_WDATA (req_wdata),
        .O_GNT       (gnt),
        .O_DONE      (done),
        .O_RDATA     (rdata),
        .O_NACK      (nack),
        .O_TIMEOUT   (tmo),
        .O_M_START   (m_start),
        .O_M_ADDR    (m_addr),
        .O_M_RW      (m_rw),
        .O_M_REG     (m_reg),
        .O_M_WDATA   (m_wdata),
        .I_M_BUSY    (m_busy),
        .I_M_DONE    (m_done),
        .I_M_NACK    (m_nack),
        .I_M_RDATA   (m_rdata),
        .O_DBG_STATE (dbg_state)
    );

    typedef struct {
        logic [N-1:0] req;
        i2c_desc_t    d0;
        i2c_desc_t    d1;
        logic [7:0]   m_rdata;
        logic         m_nack;
        logic [N-1:0] exp_gnt;
        logic [7:0]   exp_rdata;
        logic         exp_nack;
    } vec_t;

    vec_t vecs[6];

    always @(negedge clk) if (!$onehot0(gnt)) multi_gnt++;

    function automatic i2c_desc_t mk(input logic [6:0] a, input logic rw,
                                     input logic [7:0] r, input logic [7:0] w);
        i2c_desc_t d;
        d.addr = a; d.rw = rw; d.reg_idx = r; d.wdata = w;
        return d;
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total_cnt++;
        if (act === exp) pass_cnt++;
        else $display("FAIL %s: got %0h expected %0h", name, act, exp);
    endtask

    task automatic set_client(input int c, input i2c_desc_t d);
        req_addr[c*7 +: 7]  = d.addr;
        req_rw[c]           = d.rw;
        req_reg[c*8 +: 8]   = d.reg_idx;
        req_wdata[c*8 +: 8] = d.wdata;
    endtask

    task automatic wait_start();
        bit ok;
        ok = 1'b0;
        for (int i = 0; i < 50; i++) begin
            if (m_start) begin
                ok = 1'b1;
                break;
            end
            tick();
        end
        if (!ok) check("start_seen", 32'd0, 32'd1);
    endtask

    task automatic master_done(input logic [7:0] rd, input logic nk);
        m_rdata = rd;
        m_nack  = nk;
        m_done  = 1'b1;
        tick();
        m_done  = 1'b0;
    endtask

    task automatic run_vec(input int n, input vec_t v);
        i2c_desc_t exp_d;
        set_client(0, v.d0);
        set_client(1, v.d1);
        req = v.req;
        wait_start();
        exp_d = (v.exp_gnt == 2'b01) ? v.d0 : v.d1;
        check($sformatf("v%0d_gnt", n), 32'(gnt), 32'(v.exp_gnt));
        check($sformatf("v%0d_desc", n), 32'({m_addr, m_rw, m_reg, m_wdata}), 32'(exp_d));
        tick();
        check($sformatf("v%0d_start_pulse", n), 32'(m_start), 32'd0);
        tick();
        master_done(v.m_rdata, v.m_nack);
        check($sformatf("v%0d_done", n), 32'(done), 32'(v.exp_gnt));
        check($sformatf("v%0d_rdata", n), 32'(rdata), 32'(v.exp_rdata));
        check($sformatf("v%0d_nack", n), 32'(nack), 32'(v.exp_nack));
        req = '0;
        tick();
        check($sformatf("v%0d_done_drop", n), 32'({done, gnt}), 32'd0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, got hang expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        // Each pointer-dependent expectation follows from the preceding grants.
        vecs[0] = '{2'b01, mk(7'h48, 1'b0, 8'h01, 8'h60), mk(7'h00, 1'b0, 8'h00, 8'h00), 8'h00, 1'b0, 2'b01, 8'h00, 1'b0};
        vecs[1] = '{2'b10, mk(7'h00, 1'b0, 8'h00, 8'h00), mk(7'h48, 1'b1, 8'h00, 8'h00), 8'h1A, 1'b0, 2'b10, 8'h1A, 1'b0};
        vecs[2] = '{2'b01, mk(7'h50, 1'b0, 8'h10, 8'hAA), mk(7'h00, 1'b0, 8'h00, 8'h00), 8'h00, 1'b1, 2'b01, 8'h00, 1'b1};
        vecs[3] = '{2'b01, mk(7'h48, 1'b1, 8'h05, 8'h00), mk(7'h00, 1'b0, 8'h00, 8'h00), 8'hC3, 1'b0, 2'b01, 8'hC3, 1'b0};
        vecs[4] = '{2'b11, mk(7'h33, 1'b0, 8'h44, 8'h55), mk(7'h22, 1'b0, 8'h7E, 8'h5A), 8'h00, 1'b0, 2'b10, 8'h00, 1'b0};
        vecs[5] = '{2'b11, mk(7'h11, 1'b1, 8'h3C, 8'h00), mk(7'h66, 1'b1, 8'h01, 8'h00), 8'h9F, 1'b0, 2'b01, 8'h9F, 1'b0};

        rst_n = 1'b0; req = '0; req_addr = '0; req_rw = '0; req_reg = '0; req_wdata = '0;
        m_busy = 1'b0; m_done = 1'b0; m_nack = 1'b0; m_rdata = 8'h00;
        tick(); tick();
        check("rst_outputs", 32'({gnt, done, nack, tmo, m_start}), 32'd0);
        check("rst_rdata", 32'(rdata), 32'h00);
        check("rst_desc", 32'({m_addr, m_rw, m_reg, m_wdata}), 32'd0);
        check("rst_state", 32'(dbg_state), 32'(ST_IDLE));
        rst_n = 1'b1;
        tick();

        // Contention: both clients keep requesting; grants must alternate 0,1,0,1.
        set_client(0, mk(7'h48, 1'b0, 8'h01, 8'h01));
        set_client(1, mk(7'h49, 1'b0, 8'h02, 8'h02));
        req = 2'b11;
        for (int k = 0; k < 4; k++) begin
            wait_start();
            check($sformatf("cont%0d_gnt", k), 32'(gnt), (k % 2 == 0) ? 32'd1 : 32'd2);
            tick(); tick();
            master_done(8'(k), 1'b0);
            check($sformatf("cont%0d_done", k), 32'(done), (k % 2 == 0) ? 32'd1 : 32'd2);
            tick();
        end
        req = '0;
        tick();
        check("cont_onehot_gnt", 32'(multi_gnt), 32'd0);

        for (int i = 0; i < 6; i++) run_vec(i, vecs[i]);

        // Reset in WAIT: pointer is 1 here, so client1 wins first; after reset client0.
        set_client(0, mk(7'h48, 1'b0, 8'h20, 8'h21));
        set_client(1, mk(7'h49, 1'b0, 8'h30, 8'h31));
        req = 2'b11;
        wait_start();
        check("rstw_first_gnt", 32'(gnt), 32'd2);
        tick();
        check("rstw_in_wait", 32'(dbg_state), 32'(ST_WAIT));
        #2 rst_n = 1'b0;
        #1;
        check("rstw_outputs", 32'({gnt, done, nack, m_start}), 32'd0);
        check("rstw_rdata", 32'(rdata), 32'h00);
        check("rstw_desc", 32'({m_addr, m_rw, m_reg, m_wdata}), 32'd0);
        tick(); tick();
        check("rstw_no_done", 32'(done), 32'd0);
        rst_n = 1'b1;
        wait_start();
        check("rstw_regrant", 32'(gnt), 32'd1);
        check("rstw_regrant_desc", 32'({m_addr, m_reg}), 32'({7'h48, 8'h20}));
        tick();
        master_done(8'h77, 1'b0);
        check("rstw_done", 32'(done), 32'd1);
        req = '0;
        tick();

        // Busy gating, exact latency, DONE ignored outside WAIT, descriptor latching.
        m_busy = 1'b1;
        set_client(0, mk(7'h3C, 1'b1, 8'h0F, 8'h00));
        req = 2'b01;
        tick(); tick(); tick();
        check("busy_no_gnt", 32'(gnt), 32'd0);
        m_busy = 1'b0;
        tick();
        check("lat_gnt_t1", 32'(gnt), 32'd1);
        check("lat_no_start_t1", 32'(m_start), 32'd0);
        m_done = 1'b1;
        req_addr[6:0] = 7'h7F;
        tick();
        m_done = 1'b0;
        check("lat_start_t2", 32'(m_start), 32'd1);
        check("issue_done_ignored", 32'(dbg_state), 32'(ST_WAIT));
        check("desc_latched", 32'(m_addr), 32'h3C);
        tick();
        check("wait_hold", 32'({done, m_start}), 32'd0);
        check("desc_hold", 32'({m_addr, m_reg}), 32'({7'h3C, 8'h0F}));
        master_done(8'h55, 1'b0);
        check("lat_done", 32'(done), 32'd1);
        check("lat_rdata", 32'(rdata), 32'h55);
        req = '0;
        tick();
        m_done = 1'b1;
        tick();
        m_done = 1'b0;
        tick();
        check("idle_done_ignored", 32'({done, gnt}), 32'd0);
        check("idle_rdata_held", 32'(rdata), 32'h55);

`ifdef FSS_I2C_ARB_TIMEOUT_EN
        begin
            int cyc;
            cyc = 0;
            set_client(0, mk(7'h48, 1'b1, 8'h00, 8'h00));
            req = 2'b01;
            wait_start();
            for (int i = 0; i < 300; i++) begin
                if (tmo) break;
                tick();
                cyc++;
            end
            check("tmo_cycles", 32'(cyc), 32'd100);
            check("tmo_done", 32'(done), 32'd1);
            check("tmo_nack", 32'(nack), 32'd1);
            check("tmo_rdata", 32'(rdata), 32'hFF);
            req = '0;
            tick();
            check("tmo_pulse", 32'({tmo, done}), 32'd0);
        end
`endif

        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end

endmodule
